// File: rtl/pte_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pte_responder_pkg
// Brief    : Shared types and constants for the PTE responder: page-table
//            entry layout, buffer entry layout and one-hot FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package pte_responder_pkg;

    // PTEs are 8 bytes, so the low three address bits never form part of a tag
    localparam int c_PTE_OFFSET_BITS = 3;
    localparam int c_PTE_ADDR_WIDTH  = 64;
    localparam int c_TAG_WIDTH       = c_PTE_ADDR_WIDTH - c_PTE_OFFSET_BITS;

    // Sv39-style leaf/non-leaf page-table entry layout
    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } PageStruct;

    // One PTE buffer entry
    typedef struct packed {
        logic                        valid;
        logic [c_TAG_WIDTH-1:0]      tag;
        logic [c_PTE_ADDR_WIDTH-1:0] data;
    } pte_entry_t;

    // One-hot responder FSM encodings
    localparam int             c_STATE_W   = 4;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 4'b0001;
    localparam logic [c_STATE_W-1:0] c_ST_REQ  = 4'b0010;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT = 4'b0100;
    localparam logic [c_STATE_W-1:0] c_ST_RESP = 4'b1000;

endpackage : pte_responder_pkg
`default_nettype wire

// File: rtl/pte_buffer_array.sv
`default_nettype none
// ============================================================================
// Module   : pte_buffer_array
// Brief    : Fully-associative PTE buffer: entry storage, combinational
//            lookup, victim selection with round-robin pointer, and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pte_buffer_array
    import pte_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int ENTRIES    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic [ADDR_WIDTH-4:0]         i_lookup_tag,
    output logic                          o_hit,
    output logic [ADDR_WIDTH-1:0]         o_hit_data,
    output logic [$clog2(ENTRIES)-1:0]    o_hit_index,
    input  logic                          i_fill_en,
    input  logic [ADDR_WIDTH-4:0]         i_fill_tag,
    input  logic [ADDR_WIDTH-1:0]         i_fill_data
);

    localparam int c_IDX_W = $clog2(ENTRIES);

    pte_entry_t           r_entries [ENTRIES];
    logic [c_IDX_W-1:0]   r_ptr;

    logic                 w_dup_hit;
    logic [c_IDX_W-1:0]   w_dup_idx;
    logic                 w_has_free;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic [c_IDX_W-1:0]   w_victim;

    // Lookup of the walker's tag across all valid entries (tags are unique)
    always_comb begin
        o_hit       = 1'b0;
        o_hit_data  = '0;
        o_hit_index = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_entries[i].valid && (r_entries[i].tag == i_lookup_tag)) begin
                o_hit       = 1'b1;
                o_hit_data  = r_entries[i].data;
                o_hit_index = c_IDX_W'(i);
            end
        end
    end

    // Victim: existing copy of the fill tag, else lowest free slot, else pointer
    always_comb begin
        w_dup_hit  = 1'b0;
        w_dup_idx  = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_entries[i].valid && (r_entries[i].tag == i_fill_tag)) begin
                w_dup_hit = 1'b1;
                w_dup_idx = c_IDX_W'(i);
            end
            if (!r_entries[i].valid) begin
                w_has_free = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
        end
        if (w_dup_hit) begin
            w_victim = w_dup_idx;
        end else if (w_has_free) begin
            w_victim = w_free_idx;
        end else begin
            w_victim = r_ptr;
        end
    end

    // Entry storage; flush wins over a same-cycle fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
            r_ptr <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (i_fill_en) begin
            r_entries[w_victim].valid <= 1'b1;
            r_entries[w_victim].tag   <= i_fill_tag;
            r_entries[w_victim].data  <= i_fill_data;
            // Pointer only moves when a resident entry was evicted by it
            if (!w_dup_hit && !w_has_free) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

endmodule : pte_buffer_array
`default_nettype wire

// File: rtl/pte_responder.sv
`default_nettype none
// ============================================================================
// Module   : pte_responder
// Brief    : Memory-side completer for page-table-walk PTE reads. Hits are
//            answered in the request cycle; misses issue one single-beat
//            memory read, fill the buffer and return the PTE.
// Revision : 1.0 - initial release
// ============================================================================
module pte_responder
    import pte_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int ENTRIES    = 4,
    parameter int STATE_NUM  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] pa,
    input  logic                  flush,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] pte,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [ADDR_WIDTH-1:0] mem_resp_data
);

    localparam int c_TAG_W = ADDR_WIDTH - 3;
    localparam int c_IDX_W = $clog2(ENTRIES);

    localparam logic [STATE_NUM-1:0] c_IDLE = STATE_NUM'(c_ST_IDLE);
    localparam logic [STATE_NUM-1:0] c_REQ  = STATE_NUM'(c_ST_REQ);
    localparam logic [STATE_NUM-1:0] c_WAIT = STATE_NUM'(c_ST_WAIT);
    localparam logic [STATE_NUM-1:0] c_RESP = STATE_NUM'(c_ST_RESP);

    logic [STATE_NUM-1:0]  r_state;
    logic [STATE_NUM-1:0]  w_state_nxt;
    logic [c_TAG_W-1:0]    r_tag;
    logic [ADDR_WIDTH-1:0] r_resp;
    logic                  r_suppress;

    logic [c_TAG_W-1:0]    w_pa_tag;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_hit_data;
    logic [c_IDX_W-1:0]    w_hit_index;
    logic                  w_fill_en;
    logic                  w_capture;
    logic                  w_unused_bits;

    assign w_pa_tag      = pa[ADDR_WIDTH-1:3];
    assign w_unused_bits = ^{pa[2:0], w_hit_index};

    assign mem_req_valid = (r_state == c_REQ);
    assign mem_req_addr  = {r_tag, 3'b000};

    pte_buffer_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ENTRIES    (ENTRIES)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_lookup_tag (w_pa_tag),
        .o_hit        (w_hit),
        .o_hit_data   (w_hit_data),
        .o_hit_index  (w_hit_index),
        .i_fill_en    (w_fill_en),
        .i_fill_tag   (r_tag),
        .i_fill_data  (mem_resp_data)
    );

    // Next-state, walker response and fill strobe
    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        pte         = '0;
        w_fill_en   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (ren) begin
                    if (w_hit) begin
                        pte = w_hit_data;
                    end else begin
                        stall       = 1'b1;
                        w_capture   = 1'b1;
                        w_state_nxt = c_REQ;
                    end
                end
            end
            c_REQ: begin
                stall = ren;
                if (mem_req_ready) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                stall = ren;
                if (mem_resp_valid) begin
                    // A flush seen at any point of the miss makes the data stale
                    w_fill_en   = !(r_suppress || flush);
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                // Only the walker still asking for the captured tag gets the data
                if (ren && (w_pa_tag == r_tag)) begin
                    pte = r_resp;
                end else begin
                    stall = ren;
                end
                w_state_nxt = c_IDLE;
            end
            default: begin
                stall       = ren;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State, captured miss tag, response register and fill-suppress flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_tag      <= '0;
            r_resp     <= '0;
            r_suppress <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_tag      <= w_pa_tag;
                r_suppress <= 1'b0;
            end else if (((r_state == c_REQ) || (r_state == c_WAIT)) && flush) begin
                r_suppress <= 1'b1;
            end
            if ((r_state == c_WAIT) && mem_resp_valid) begin
                r_resp <= mem_resp_data;
            end
        end
    end

endmodule : pte_responder
`default_nettype wire

// File: tb/tb_pte_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pte_responder
// Brief    : Self-checking bench for pte_responder with a behavioural PTE
//            buffer model and a delay-configurable memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pte_responder;

    localparam int AW = 64;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren;
    logic [AW-1:0] pa;
    logic          flush;
    logic          stall;
    logic [AW-1:0] pte;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid;
    logic [AW-1:0] mem_resp_data;

    int n_total = 0;
    int n_pass  = 0;

    // memory responder controls / observations
    int            req_delay = 0;
    int            resp_delay = 0;
    int            m_phase = 0;
    int            m_cnt = 0;
    int            req_count = 0;
    int            resp_count = 0;
    int            stray_req_cnt = 0;
    int            stray_done_cnt = 0;
    logic [AW-1:0] m_addr = '0;

    // reference model: residency per slot plus round-robin pointer
    bit            mv [NE];
    logic [60:0]   mt [NE];
    int            mptr = 0;

    always #5 clk = ~clk;

    pte_responder #(.ADDR_WIDTH(AW), .ENTRIES(NE), .STATE_NUM(4)) dut (
        .clk(clk), .rst(rst), .ren(ren), .pa(pa), .flush(flush),
        .stall(stall), .pte(pte),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    // memory image: fixed content per 8-byte aligned address
    function automatic logic [AW-1:0] img(input logic [AW-1:0] a);
        logic [AW-1:0] al;
        al = {a[AW-1:3], 3'b000};
        if (al == 64'h0000_0000_8000_1008) return 64'h0000_0000_2000_04C1;
        return {al[31:0] ^ 32'h5A5A_1234, al[63:32] + 32'h0000_00C1};
    endfunction

    function automatic bit m_hit(input logic [AW-1:0] a);
        for (int i = 0; i < NE; i++) if (mv[i] && mt[i] == a[AW-1:3]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [AW-1:0] a);
        int v;
        v = -1;
        for (int i = 0; i < NE; i++) if (!mv[i]) begin v = i; break; end
        if (v < 0) begin
            v    = mptr;
            mptr = (mptr + 1) % NE;
        end
        mv[v] = 1'b1;
        mt[v] = a[AW-1:3];
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NE; i++) mv[i] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_clear();
        mptr = 0;
    endfunction

    // memory fabric: ready after req_delay cycles, response resp_delay cycles after handshake
    initial begin : mem_model
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
            if (rst) begin
                m_phase = 0;
            end else if (stray_req_cnt != stray_done_cnt) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 64'hDEAD_BEEF_0000_0008;
                stray_done_cnt++;
            end else begin
                if (m_phase == 0 && mem_req_valid) begin
                    m_cnt   = req_delay;
                    m_phase = 1;
                end
                if (m_phase == 1) begin
                    if (m_cnt == 0) begin
                        mem_req_ready = 1'b1;
                        m_addr        = mem_req_addr;
                        req_count++;
                        m_phase = 2;
                        m_cnt   = resp_delay;
                    end else begin
                        m_cnt--;
                    end
                end else if (m_phase == 2) begin
                    if (m_cnt == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = img(m_addr);
                        resp_count++;
                        m_phase = 0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // walker-side read: hold ren until stall low; returns observations only
    task automatic do_read(input logic [AW-1:0] addr, output logic first_stall,
                           output logic [AW-1:0] data, output int lat, output bit timeout);
        ren = 1'b1; pa = addr; lat = 0; timeout = 1'b0; data = '0;
        @(negedge clk);
        first_stall = stall;
        while (stall && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (stall) timeout = 1'b1;
        else       data = pte;
        @(posedge clk); #1;
        ren = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; ren = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; ren = 1'b1; pa = 64'h1234_5678; flush = 1'b0;
        @(negedge clk);
        n_total++;
        if (stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", stall); else n_pass++;
        n_total++;
        if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        n_total++;
        if (mem_req_addr !== 64'h0) $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); else n_pass++;
        ren = 1'b0; #1;
        n_total++;
        if (stall !== 1'b0 || pte !== 64'h0) $display("FAIL reset_idle_out: stall=%b pte=%h want 0/0", stall, pte); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        m_reset();
    endtask

    task automatic test_cold_miss();
        logic exp_stall, exp_valid;
        req_delay = 2; resp_delay = 3;
        ren = 1'b1; pa = 64'h8000_1008;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            exp_stall = (c < 8);
            exp_valid = (c >= 1 && c <= 3);
            n_total++;
            if (stall !== exp_stall || mem_req_valid !== exp_valid)
                $display("FAIL cold_miss_cycle%0d: stall=%b valid=%b want %b/%b", c, stall, mem_req_valid, exp_stall, exp_valid);
            else n_pass++;
            if (exp_valid) begin
                n_total++;
                if (mem_req_addr !== 64'h8000_1008) $display("FAIL cold_miss_addr: got %h want 0000000080001008", mem_req_addr); else n_pass++;
            end
        end
        n_total++;
        if (pte !== 64'h2000_04C1) $display("FAIL cold_miss_pte: got %h want 00000000200004c1", pte); else n_pass++;
        @(posedge clk); #1 ren = 1'b0;
        m_fill(64'h8000_1008);
    endtask

    task automatic test_hit();
        logic fs; logic [AW-1:0] d; int lat; bit to; int rc;
        rc = req_count;
        do_read(64'h8000_100F, fs, d, lat, to);
        n_total++;
        if (fs !== 1'b0 || to) $display("FAIL hit_latency: first_stall=%b timeout=%0d want 0/0", fs, to); else n_pass++;
        n_total++;
        if (d !== 64'h2000_04C1) $display("FAIL hit_data: got %h want 00000000200004c1", d); else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_req_valid !== 1'b0 || req_count != rc) $display("FAIL hit_no_mem: valid=%b reqs=%0d want 0/%0d", mem_req_valid, req_count, rc); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_replacement();
        logic fs; logic [AW-1:0] d; int lat; bit to; bit eh;
        logic [AW-1:0] t [5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            t[i] = 64'h9000_0000 + (64'(i) << 12) + 64'($urandom_range(0, 7));
            req_delay = $urandom_range(0, 3); resp_delay = $urandom_range(0, 3);
            eh = m_hit(t[i]);
            do_read(t[i], fs, d, lat, to);
            n_total++;
            if (fs !== !eh || to || d !== img(t[i])) $display("FAIL repl_fill%0d: stall0=%b data=%h want %b/%h", i, fs, d, !eh, img(t[i])); else n_pass++;
            if (!eh) m_fill(t[i]);
        end
        // second tag survives, first tag was the victim of the fifth fill
        eh = m_hit(t[1]);
        do_read(t[1], fs, d, lat, to);
        n_total++;
        if (fs !== !eh || eh !== 1'b1 || d !== img(t[1])) $display("FAIL repl_second_hit: stall0=%b data=%h want 0/%h", fs, d, img(t[1])); else n_pass++;
        eh = m_hit(t[0]);
        do_read(t[0], fs, d, lat, to);
        n_total++;
        if (fs !== !eh || eh !== 1'b0 || d !== img(t[0])) $display("FAIL repl_first_miss: stall0=%b data=%h want 1/%h", fs, d, img(t[0])); else n_pass++;
        if (!eh) m_fill(t[0]);
    endtask

    task automatic test_flush_idle();
        logic fs; logic [AW-1:0] d; int lat; bit to; bit eh;
        logic [AW-1:0] t;
        t  = 64'h9000_4000;
        eh = m_hit(t);
        // lookup in the flush cycle still sees old contents
        flush = 1'b1; ren = 1'b1; pa = t;
        @(negedge clk);
        n_total++;
        if (stall !== !eh || (eh && pte !== img(t))) $display("FAIL flush_same_cycle: stall=%b pte=%h want %b/%h", stall, pte, !eh, img(t)); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0; ren = 1'b0;
        m_clear();
        do_read(64'h9000_3000, fs, d, lat, to);
        n_total++;
        if (fs !== 1'b1 || to || d !== img(64'h9000_3000)) $display("FAIL flush_next_miss: stall0=%b data=%h want 1/%h", fs, d, img(64'h9000_3000)); else n_pass++;
        m_fill(64'h9000_3000);
    endtask

    task automatic test_flush_inflight();
        logic fs; logic [AW-1:0] d; int lat; bit to;
        logic [AW-1:0] a;
        for (int mode = 0; mode < 2; mode++) begin
            a = 64'hD000_0008 + (64'(mode) << 12);
            req_delay = 0; resp_delay = 4;
            fork
                do_read(a, fs, d, lat, to);
                begin
                    if (mode == 0) begin
                        for (int k = 0; k < 100 && m_phase != 2; k++) @(negedge clk);
                        @(posedge clk); #1;
                    end else begin
                        for (int k = 0; k < 100 && !mem_resp_valid; k++) @(negedge clk);
                    end
                    flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                end
            join
            m_clear();
            n_total++;
            if (fs !== 1'b1 || to || d !== img(a)) $display("FAIL flush_inflight%0d_resp: stall0=%b to=%0d data=%h want 1/0/%h", mode, fs, to, d, img(a)); else n_pass++;
            do_read(a, fs, d, lat, to);
            n_total++;
            if (fs !== 1'b1 || to || d !== img(a)) $display("FAIL flush_inflight%0d_refetch: stall0=%b data=%h want 1/%h", mode, fs, d, img(a)); else n_pass++;
            m_fill(a);
        end
    endtask

    task automatic test_abandon();
        logic fs; logic [AW-1:0] d; int lat; bit to; int rc; bit bad; int k;
        logic [AW-1:0] a, b;
        a = 64'hB000_0010; b = 64'hB000_0020;
        req_delay = 1; resp_delay = 5;
        ren = 1'b1; pa = a;
        for (k = 0; k < 100 && m_phase != 2; k++) @(negedge clk);
        @(posedge clk); #1 ren = 1'b0;
        rc = resp_count;
        repeat (2) @(posedge clk);
        #1 ren = 1'b1; pa = b;
        bad = 1'b0;
        for (k = 0; k < 100 && resp_count == rc; k++) begin
            @(negedge clk);
            if (stall !== 1'b1) bad = 1'b1;
        end
        repeat (2) begin
            @(negedge clk);
            if (stall !== 1'b1) bad = 1'b1;
        end
        n_total++;
        if (bad || resp_count == rc) $display("FAIL abandon_no_release: early_release=%0d resps=%0d want 0/%0d", bad, resp_count, rc + 1); else n_pass++;
        for (k = 0; k < 100 && stall; k++) @(negedge clk);
        n_total++;
        if (stall !== 1'b0 || pte !== img(b)) $display("FAIL abandon_new_tag: stall=%b pte=%h want 0/%h", stall, pte, img(b)); else n_pass++;
        @(posedge clk); #1 ren = 1'b0;
        m_fill(a); m_fill(b);
        do_read(a, fs, d, lat, to);
        n_total++;
        if (fs !== 1'b0 || d !== img(a)) $display("FAIL abandon_later_hit: stall0=%b data=%h want 0/%h", fs, d, img(a)); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic fs; logic [AW-1:0] d; int lat; bit to; bit eh;
        logic [AW-1:0] x, y;
        x = 64'hC000_0000; y = 64'hC000_1000;
        req_delay = 0; resp_delay = 6;
        eh = m_hit(x);
        do_read(x, fs, d, lat, to);
        if (!eh) m_fill(x);
        ren = 1'b1; pa = y;
        for (int k = 0; k < 100 && m_phase != 2; k++) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        n_total++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) $display("FAIL areset_mem: valid=%b addr=%h want 0/0", mem_req_valid, mem_req_addr); else n_pass++;
        pa = x; #1;
        n_total++;
        if (stall !== 1'b1) $display("FAIL areset_entries: stall=%b want 1", stall); else n_pass++;
        ren = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_reset();
        stray_req_cnt++;
        repeat (3) @(posedge clk);
        #1;
        do_read(64'h0, fs, d, lat, to);
        n_total++;
        if (fs !== 1'b1 || to || d !== img(64'h0)) $display("FAIL areset_stray_nofill: stall0=%b data=%h want 1/%h", fs, d, img(64'h0)); else n_pass++;
        m_fill(64'h0);
        do_read(y, fs, d, lat, to);
        n_total++;
        if (fs !== 1'b1 || to || d !== img(y)) $display("FAIL areset_refetch: stall0=%b data=%h want 1/%h", fs, d, img(y)); else n_pass++;
        m_fill(y);
    endtask

    task automatic test_random();
        logic fs; logic [AW-1:0] d; int lat; bit to; bit eh; int rc;
        logic [AW-1:0] a;
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
                m_clear();
            end
            a = 64'hA000_0000 + (64'($urandom_range(0, 6)) << 3) * 64'h200 + 64'($urandom_range(0, 7));
            req_delay = $urandom_range(0, 3); resp_delay = $urandom_range(0, 3);
            eh = m_hit(a);
            rc = req_count;
            do_read(a, fs, d, lat, to);
            n_total++;
            if (fs !== !eh || to) $display("FAIL rand%0d_hit: stall0=%b to=%0d want %b/0", it, fs, to, !eh); else n_pass++;
            n_total++;
            if (d !== img(a)) $display("FAIL rand%0d_data: got %h want %h", it, d, img(a)); else n_pass++;
            n_total++;
            if (req_count != rc + (eh ? 0 : 1)) $display("FAIL rand%0d_reqs: got %0d want %0d", it, req_count - rc, eh ? 0 : 1); else n_pass++;
            if (!eh) m_fill(a);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached (%0d/%0d passed)", n_pass, n_total);
        $fatal(1);
    end

    initial begin : main
        ren = 1'b0; pa = '0; flush = 1'b0; rst = 1'b1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_replacement();
        test_flush_idle();
        test_flush_inflight();
        test_abandon();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pte_responder
`default_nettype wire
